// File: rtl/button_event_scheduler.sv
// Converts debounced button levels into PRESS/RELEASE/LONG/REPEAT events and
// merges all buttons onto one round-robin arbitrated valid/ready event stream.
module button_event_scheduler #(
    parameter int          BUTTON_WIDTH = 4,
    parameter int          ID_WIDTH     = 2,
    parameter logic [31:0] HOLD_COUNT   = 32'd50_000_000,
    parameter logic [31:0] REPEAT_COUNT = 32'd10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUTTON_WIDTH-1:0] btn,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [ID_WIDTH-1:0]     evt_id,
    output logic [1:0]              evt_type,
    output logic [BUTTON_WIDTH-1:0] overflow
);

    // Handshake: an event transfers on a clock edge where evt_valid & evt_ready;
    // while evt_valid & ~evt_ready, evt_valid/evt_id/evt_type are held stable.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    logic [BUTTON_WIDTH-1:0] btn_q, rise, fall;
    state_t                  state_q [BUTTON_WIDTH];
    state_t                  state_d [BUTTON_WIDTH];
    logic [31:0]             cnt_q   [BUTTON_WIDTH];
    logic [31:0]             cnt_d   [BUTTON_WIDTH];
    logic [BUTTON_WIDTH-1:0] gen_v;
    logic [1:0]              gen_t   [BUTTON_WIDTH];
    logic [BUTTON_WIDTH-1:0] pend_v;
    logic [1:0]              pend_t  [BUTTON_WIDTH];
    logic [BUTTON_WIDTH-1:0] slot_grant;
    logic [ID_WIDTH-1:0]     rr_ptr, grant_idx, ptr_next;
    logic                    grant_any, out_free;

    assign rise     = btn & ~btn_q;
    assign fall     = ~btn & btn_q;
    assign out_free = ~evt_valid | evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= '0;
            for (int i = 0; i < BUTTON_WIDTH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            btn_q <= btn;
            for (int i = 0; i < BUTTON_WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // A fall always wins over a LONG/REPEAT that would fire on the same edge.
    always_comb begin
        for (int i = 0; i < BUTTON_WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = S_PRESSED;
                        cnt_d[i]   = '0;
                    end
                end
                S_PRESSED: begin
                    if (fall[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == HOLD_COUNT - 32'd1) begin
                        state_d[i] = S_HELD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                S_HELD: begin
                    if (fall[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (REPEAT_COUNT == 32'd0 || cnt_q[i] == REPEAT_COUNT - 32'd1) begin
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        gen_v = '0;
        for (int i = 0; i < BUTTON_WIDTH; i++) begin
            gen_t[i] = EV_PRESS;
            case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EV_PRESS;
                    end
                end
                S_PRESSED: begin
                    if (fall[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EV_RELEASE;
                    end else if (cnt_q[i] == HOLD_COUNT - 32'd1) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EV_LONG;
                    end
                end
                S_HELD: begin
                    if (fall[i]) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EV_RELEASE;
                    end else if (REPEAT_COUNT != 32'd0 && cnt_q[i] == REPEAT_COUNT - 32'd1) begin
                        gen_v[i] = 1'b1;
                        gen_t[i] = EV_REPEAT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin search starting at rr_ptr, wrapping at BUTTON_WIDTH.
    always_comb begin
        int                  j;
        logic [ID_WIDTH-1:0] idx;
        j         = 0;
        idx       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (out_free) begin
            for (int off = 0; off < BUTTON_WIDTH; off++) begin
                j = int'(rr_ptr) + off;
                if (j >= BUTTON_WIDTH) j = j - BUTTON_WIDTH;
                idx = ID_WIDTH'(j);
                if (!grant_any && pend_v[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = idx;
                end
            end
        end
    end

    always_comb begin
        slot_grant = '0;
        for (int i = 0; i < BUTTON_WIDTH; i++)
            slot_grant[i] = grant_any && (grant_idx == ID_WIDTH'(i));
        ptr_next = (grant_idx == ID_WIDTH'(BUTTON_WIDTH - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= '0;
            overflow  <= '0;
            rr_ptr    <= '0;
            pend_v    <= '0;
            for (int i = 0; i < BUTTON_WIDTH; i++) pend_t[i] <= '0;
        end else begin
            if (out_free) begin
                evt_valid <= grant_any;
                if (grant_any) begin
                    evt_id   <= grant_idx;
                    evt_type <= pend_t[grant_idx];
                    rr_ptr   <= ptr_next;
                end
            end
            // A slot being granted this edge may take a new event without loss.
            for (int i = 0; i < BUTTON_WIDTH; i++) begin
                if (gen_v[i]) begin
                    if (pend_v[i] && !slot_grant[i]) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        pend_v[i] <= 1'b1;
                        pend_t[i] <= gen_t[i];
                    end
                end else if (slot_grant[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: two instances (REPEAT_COUNT 4 and 0) checked
// every cycle against an event-timing model, plus directed literal expectations.
module tb_button_event_scheduler;
    localparam int BW   = 4;
    localparam int NI   = 2;
    localparam int HOLD = 8;
    localparam int EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3;

    typedef struct {
        int inst;
        int t;
        int id;
        int ty;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [BW-1:0]         btn;
    logic                  evt_ready;
    logic [NI-1:0]         d_valid;
    logic [NI-1:0][1:0]    d_id;
    logic [NI-1:0][1:0]    d_type;
    logic [NI-1:0][BW-1:0] d_ovf;

    int checks   = 0;
    int failures = 0;

    button_event_scheduler #(
        .BUTTON_WIDTH(BW), .ID_WIDTH(2), .HOLD_COUNT(32'd8), .REPEAT_COUNT(32'd4)
    ) dut0 (
        .clk(clk), .reset(reset), .btn(btn), .evt_valid(d_valid[0]), .evt_ready(evt_ready),
        .evt_id(d_id[0]), .evt_type(d_type[0]), .overflow(d_ovf[0])
    );

    button_event_scheduler #(
        .BUTTON_WIDTH(BW), .ID_WIDTH(2), .HOLD_COUNT(32'd8), .REPEAT_COUNT(32'd0)
    ) dut1 (
        .clk(clk), .reset(reset), .btn(btn), .evt_valid(d_valid[1]), .evt_ready(evt_ready),
        .evt_id(d_id[1]), .evt_type(d_type[1]), .overflow(d_ovf[1])
    );

    always #5 clk = ~clk;

    // Reference model: events derived from the press time, slots, output register.
    int            rep_p [NI] = '{4, 0};
    int            edge_n = 0;
    logic [BW-1:0] m_bq = '0;
    bit            m_held [NI][BW];
    int            m_t0   [NI][BW];
    bit            m_pv   [NI][BW];
    int            m_pt   [NI][BW];
    bit            m_ovf  [NI][BW];
    bit            m_v    [NI];
    int            m_id   [NI];
    int            m_ty   [NI];
    int            m_ptr  [NI];
    ev_t           xfer_q [$];
    ev_t           gen_q  [$];

    always @(posedge clk) begin
        bit  free;
        int  g, ev, d, j;
        ev_t e;
        edge_n++;
        for (int m = 0; m < NI; m++) begin
            if (reset) begin
                m_v[m] = 0; m_id[m] = 0; m_ty[m] = 0; m_ptr[m] = 0;
                for (int i = 0; i < BW; i++) begin
                    m_held[m][i] = 0; m_t0[m][i] = 0; m_pv[m][i] = 0;
                    m_pt[m][i] = 0; m_ovf[m][i] = 0;
                end
            end else begin
                free = !m_v[m] || evt_ready;
                if (m_v[m] && evt_ready) begin
                    e.inst = m; e.t = edge_n; e.id = m_id[m]; e.ty = m_ty[m];
                    xfer_q.push_back(e);
                end
                g = -1;
                if (free) begin
                    for (int off = 0; off < BW; off++) begin
                        j = (m_ptr[m] + off) % BW;
                        if (g < 0 && m_pv[m][j]) g = j;
                    end
                    if (g >= 0) begin
                        m_v[m] = 1; m_id[m] = g; m_ty[m] = m_pt[m][g];
                        m_pv[m][g] = 0; m_ptr[m] = (g + 1) % BW;
                    end else begin
                        m_v[m] = 0;
                    end
                end
                for (int i = 0; i < BW; i++) begin
                    ev = -1;
                    if (btn[i] && !m_bq[i]) begin
                        ev = EV_PRESS; m_held[m][i] = 1; m_t0[m][i] = edge_n;
                    end else if (!btn[i] && m_bq[i]) begin
                        if (m_held[m][i]) ev = EV_RELEASE;
                        m_held[m][i] = 0;
                    end else if (m_held[m][i]) begin
                        d = edge_n - m_t0[m][i];
                        if (d == HOLD) ev = EV_LONG;
                        else if (rep_p[m] != 0 && d > HOLD && (d - HOLD) % rep_p[m] == 0) ev = EV_REPEAT;
                    end
                    if (ev >= 0) begin
                        e.inst = m; e.t = edge_n; e.id = i; e.ty = ev;
                        gen_q.push_back(e);
                        if (m_pv[m][i]) m_ovf[m][i] = 1;
                        else begin m_pv[m][i] = 1; m_pt[m][i] = ev; end
                    end
                end
            end
        end
        m_bq = reset ? '0 : btn;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [BW-1:0] eo;
        for (int m = 0; m < NI; m++) begin
            for (int i = 0; i < BW; i++) eo[i] = m_ovf[m][i];
            chk($sformatf("cyc_valid_i%0d", m), d_valid[m], m_v[m]);
            if (m_v[m]) begin
                chk($sformatf("cyc_id_i%0d", m), d_id[m], m_id[m]);
                chk($sformatf("cyc_type_i%0d", m), d_type[m], m_ty[m]);
            end
            chk($sformatf("cyc_ovf_i%0d", m), d_ovf[m], eo);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        xfer_q.delete();
        gen_q.delete();
    endtask

    // Transferred events of one instance, encoded id*4+type, against a literal list.
    task automatic chk_seq(input string nm, input int m, input int n, input int e[6]);
        int got[$];
        foreach (xfer_q[k]) if (xfer_q[k].inst == m) got.push_back(xfer_q[k].id * 4 + xfer_q[k].ty);
        chk({nm, "_count"}, got.size(), n);
        for (int k = 0; k < n; k++)
            if (k < got.size()) chk($sformatf("%s_%0d", nm, k), got[k], e[k]);
    endtask

    initial begin
        int tq[$];
        int pct, b, nrep;

        reset = 1'b1; btn = '0; evt_ready = 1'b1;
        tick(3);
        for (int m = 0; m < NI; m++) begin
            chk("reset_valid", d_valid[m], 0);
            chk("reset_id", d_id[m], 0);
            chk("reset_type", d_type[m], 0);
            chk("reset_ovf", d_ovf[m], 0);
        end
        reset = 1'b0;
        tick(2);

        // Short press: PRESS then RELEASE, two-edge latency to the output.
        clear_logs();
        btn = 4'b0010;
        tick(1);
        chk("t1_lat_valid0", d_valid[0], 0);
        tick(1);
        chk("t1_lat_valid1", d_valid[0], 1);
        chk("t1_lat_id", d_id[0], 1);
        chk("t1_lat_type", d_type[0], EV_PRESS);
        tick(1);
        btn = '0;
        tick(6);
        chk_seq("t1_seq", 0, 2, '{4, 5, 0, 0, 0, 0});
        chk("t1_ovf", d_ovf[0], 0);

        // Long hold: LONG at +8, REPEATs every 4 after it, RELEASE on the fall.
        clear_logs();
        btn = 4'b0100;
        tick(21);
        btn = '0;
        tick(6);
        chk_seq("t2_seq_r4", 0, 6, '{8, 10, 11, 11, 11, 9});
        chk_seq("t2_seq_r0", 1, 3, '{8, 10, 9, 0, 0, 0});
        tq.delete();
        foreach (gen_q[k]) if (gen_q[k].inst == 0) tq.push_back(gen_q[k].t);
        chk("t2_gen_n", tq.size(), 6);
        if (tq.size() >= 6) begin
            chk("t2_long_dt", tq[1] - tq[0], 8);
            chk("t2_rep1_dt", tq[2] - tq[1], 4);
            chk("t2_rep2_dt", tq[3] - tq[1], 8);
            chk("t2_rep3_dt", tq[4] - tq[1], 12);
            chk("t2_rel_dt", tq[5] - tq[0], 21);
        end

        // Simultaneous presses and releases drain round-robin on consecutive cycles.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        clear_logs();
        btn = 4'b1011;
        tick(5);
        btn = '0;
        tick(8);
        chk_seq("t3_seq", 0, 6, '{0, 4, 12, 1, 5, 13});
        tq.delete();
        foreach (xfer_q[k]) if (xfer_q[k].inst == 0) tq.push_back(xfer_q[k].t);
        if (tq.size() >= 6) begin
            chk("t3_press_gap1", tq[1] - tq[0], 1);
            chk("t3_press_gap2", tq[2] - tq[1], 1);
            chk("t3_rel_gap1", tq[4] - tq[3], 1);
            chk("t3_rel_gap2", tq[5] - tq[4], 1);
        end

        // Back-pressure: output held, one RELEASE pending, later events dropped.
        clear_logs();
        evt_ready = 1'b0;
        btn = 4'b0001; tick(2);
        btn = 4'b0000; tick(2);
        btn = 4'b0001; tick(2);
        btn = 4'b0000; tick(2);
        chk("t4_held_valid", d_valid[0], 1);
        chk("t4_held_id", d_id[0], 0);
        chk("t4_held_type", d_type[0], EV_PRESS);
        chk("t4_ovf_set", d_ovf[0], 4'b0001);
        evt_ready = 1'b1;
        tick(4);
        chk_seq("t4_drain", 0, 2, '{0, 1, 0, 0, 0, 0});
        chk("t4_ovf_sticky", d_ovf[0], 4'b0001);
        chk("t4_drained_valid", d_valid[0], 0);

        // Reset while HELD with a stalled output; a still-held button re-presses.
        clear_logs();
        evt_ready = 1'b0;
        btn = 4'b0100;
        tick(11);
        chk("t5_pre_valid", d_valid[0], 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int m = 0; m < NI; m++) begin
            chk("t5_rst_valid", d_valid[m], 0);
            chk("t5_rst_id", d_id[m], 0);
            chk("t5_rst_type", d_type[m], 0);
            chk("t5_rst_ovf", d_ovf[m], 0);
        end
        tick(1);
        chk("t5_post1_valid", d_valid[0], 0);
        tick(1);
        chk("t5_post2_valid", d_valid[0], 1);
        chk("t5_post2_id", d_id[0], 2);
        chk("t5_post2_type", d_type[0], EV_PRESS);
        evt_ready = 1'b1;
        btn = '0;
        tick(6);

        // REPEAT disabled on instance 1; instance 0 emits ten REPEATs.
        clear_logs();
        btn = 4'b1000;
        tick(50);
        btn = '0;
        tick(6);
        chk_seq("t6_seq_r0", 1, 3, '{12, 14, 13, 0, 0, 0});
        nrep = 0;
        foreach (xfer_q[k]) if (xfer_q[k].inst == 0 && xfer_q[k].ty == EV_REPEAT) nrep++;
        chk("t6_rep_count_r4", nrep, 10);

        // Random buttons, bursty ready, occasional reset.
        for (int c = 0; c < 1600; c++) begin
            pct = ((c / 200) % 2 == 0) ? 90 : 25;
            if ($urandom_range(0, 15) == 0) begin
                b = $urandom_range(0, BW - 1);
                btn[b] = ~btn[b];
            end
            evt_ready = ($urandom_range(0, 99) < pct);
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 1'b0;
        btn = '0;
        evt_ready = 1'b1;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
